// File: rtl/flex_counter_mm.sv
// flex_counter_mm: multi-mode up/down counter with a programmable rollover value.
// It has synchronous clear and load, wrap or one-shot operation, a level rollover
// flag and a one-cycle rollover pulse. A small IDLE/RUN/DONE FSM tracks activity.
module flex_counter_mm #(
    parameter int unsigned NUM_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load_en,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    up_down,
    input  logic                    one_shot,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    rollover_pulse,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;
    logic                    pulse_q, pulse_d;

    logic [NUM_CNT_BITS-1:0] term;
    logic [NUM_CNT_BITS-1:0] step_val;
    logic                    rv_zero;
    logic                    step_hits_term;

    // Terminal value depends on the direction sampled this cycle.
    always_comb begin
        rv_zero = (rollover_val == '0);
        term    = up_down ? rollover_val : ONE;
    end

    // Value the counter would take on an enabled step; out-of-range counts are
    // pulled back into 1..rollover_val.
    always_comb begin
        step_val = count_q;
        if (rv_zero) begin
            step_val = '0;
        end else if (up_down) begin
            if (count_q >= rollover_val) begin
                step_val = ONE;
            end else begin
                step_val = count_q + ONE;
            end
        end else begin
            if ((count_q <= ONE) || (count_q > rollover_val)) begin
                step_val = rollover_val;
            end else begin
                step_val = count_q - ONE;
            end
        end
        step_hits_term = !rv_zero && (step_val == term);
    end

    // Next-state, next-count and flag computation in priority order:
    // clear, then load, then an enabled step, then hold.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = 1'b0;
        // A held count keeps the level flag consistent with the current terminal
        // value. DONE freezes the flag along with the count.
        flag_d  = (state_q == DONE) ? flag_q : (!rv_zero && (count_q == term));

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            flag_d  = 1'b0;
        end else if (load_en) begin
            state_d = IDLE;
            count_d = load_val;
            flag_d  = !rv_zero && (load_val == term);
        end else if (count_enable && (state_q != DONE)) begin
            count_d = step_val;
            if (rv_zero) begin
                state_d = IDLE;
                flag_d  = 1'b0;
            end else begin
                flag_d  = step_hits_term;
                pulse_d = step_hits_term;
                state_d = (one_shot && step_hits_term) ? DONE : RUN;
            end
        end
    end

    // State, count and flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        count_out      = count_q;
        rollover_flag  = flag_q;
        rollover_pulse = pulse_q;
        busy           = (state_q == RUN);
        done           = (state_q == DONE);
    end

endmodule

// File: tb/tb_flex_counter_mm.sv
// Directed self-checking bench for flex_counter_mm. The expected values are
// worked out by hand from the counter behaviour.
module tb_flex_counter_mm;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       load_en;
    logic [7:0] load_val;
    logic       count_enable;
    logic       up_down;
    logic       one_shot;
    logic [7:0] rollover_val;
    logic [7:0] count_out;
    logic       rollover_flag;
    logic       rollover_pulse;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    flex_counter_mm #(.NUM_CNT_BITS(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .load_en       (load_en),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .up_down       (up_down),
        .one_shot      (one_shot),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .rollover_pulse(rollover_pulse),
        .busy          (busy),
        .done          (done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input logic f,
                           input logic p, input logic b, input logic d);
        chk({tag, ".count"}, 32'(count_out), 32'(c));
        chk({tag, ".flag"},  32'(rollover_flag), 32'(f));
        chk({tag, ".pulse"}, 32'(rollover_pulse), 32'(p));
        chk({tag, ".busy"},  32'(busy), 32'(b));
        chk({tag, ".done"},  32'(done), 32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e;
        n_rst = 1'b0; clear = 1'b0; load_en = 1'b0; load_val = '0;
        count_enable = 1'b0; up_down = 1'b1; one_shot = 1'b0; rollover_val = 8'd5;
        #12;
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;

        // 1: wrap up-count, rollover 5
        tick();
        count_enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = 8'((i % 5) + 1);
            chk_all($sformatf("up%0d", i), e, e == 8'd5, e == 8'd5, 1'b1, 1'b0);
        end

        // 2: wrap down-count from 0, rollover 4
        count_enable = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_all("clr2", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        up_down = 1'b0; rollover_val = 8'd4; count_enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            e = 8'(4 - (i % 4));
            chk_all($sformatf("dn%0d", i), e, e == 8'd1, e == 8'd1, 1'b1, 1'b0);
        end

        // 3: one-shot up to 3, then frozen
        count_enable = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        up_down = 1'b1; one_shot = 1'b1; rollover_val = 8'd3; count_enable = 1'b1;
        tick(); chk_all("os1", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("os2", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("os3", 8'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) one_shot = 1'b0;   // leaving one-shot does not exit DONE
            tick();
            chk_all($sformatf("oshold%0d", i), 8'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_all("osclr", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: priority clear > load > enable, then load wins over enable
        clear = 1'b1; load_en = 1'b1; load_val = 8'd7;
        tick();
        chk_all("prio_clr", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0; rollover_val = 8'd7;
        tick();
        chk_all("prio_ld", 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);

        // 5: rollover change mid-count, then rollover 0
        load_val = 8'd9; rollover_val = 8'd10; count_enable = 1'b0;
        tick();
        load_en = 1'b0;
        chk_all("ld9", 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        rollover_val = 8'd6; count_enable = 1'b1;
        tick();
        chk_all("rv6", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        rollover_val = 8'd0;
        tick();
        chk_all("rv0", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Direction change mid-count and loading onto the down terminal value
        clear = 1'b1;
        tick();
        clear = 1'b0; rollover_val = 8'd5; up_down = 1'b1;
        tick(); tick();
        chk_all("dir_up", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        up_down = 1'b0;
        tick();
        chk_all("dir_dn", 8'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        up_down = 1'b1;
        tick();
        chk_all("dir_up2", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        up_down = 1'b0; load_en = 1'b1; load_val = 8'd1;
        tick();
        load_en = 1'b0; count_enable = 1'b0;
        chk_all("ld_term", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset in the middle of a run
        clear = 1'b1;
        tick();
        clear = 1'b0; up_down = 1'b1; rollover_val = 8'd5; count_enable = 1'b1;
        tick(); tick(); tick();
        chk_all("pre_rst", 8'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        count_enable = 1'b0;
        #10;
        n_rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
